counter4_sweep_ctrl: RTL and testbench

COUNTER4_SWEEP_CTRL -- requirements
Module: counter4_sweep_ctrl

---
 rtl/counter4_sweep_ctrl.sv | 134 +++++++++++++
 tb/tb_counter4_sweep_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter4_sweep_ctrl.sv
// Sweeps an external 4-bit up/down counter lo->hi->lo a set number of times, dwelling HOLD_CYCLES at each end.
// en/up_down are combinational from state and cnt; stop or a counter wrap flag aborts the job on the next edge.
module counter4_sweep_ctrl #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] lo,
  input  logic [3:0] hi,
  input  logic [3:0] sweeps,
  input  logic [3:0] cnt,
  input  logic       overflow,
  input  logic       underflow,
  output logic       en,
  output logic       up_down,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] sweep_idx
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEEK     = 3'd1;
  localparam logic [2:0] S_UP       = 3'd2;
  localparam logic [2:0] S_HOLD_TOP = 3'd3;
  localparam logic [2:0] S_DOWN     = 3'd4;
  localparam logic [2:0] S_HOLD_BOT = 3'd5;

  // A zero dwell still spends one cycle in the hold state.
  localparam logic [3:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 4'd0 : 4'(HOLD_CYCLES - 1);

  logic [2:0] state;
  logic [3:0] hold_cnt;
  logic [3:0] lo_q;
  logic [3:0] hi_q;
  logic [3:0] sweeps_q;
  logic       abort;
  logic       hold_done;

  assign busy      = (state != S_IDLE);
  assign abort     = busy && (stop || overflow || underflow);
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign up_down   = !((state == S_DOWN) || (state == S_HOLD_BOT));

  always_comb begin
    en = 1'b0;
    case (state)
      S_SEEK:  en = (cnt != lo_q);
      S_UP:    en = (cnt != hi_q);
      S_DOWN:  en = (cnt != lo_q);
      default: en = 1'b0;
    endcase
    if (abort) en = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hold_cnt  <= 4'd0;
      lo_q      <= 4'd0;
      hi_q      <= 4'd0;
      sweeps_q  <= 4'd0;
      sweep_idx <= 4'd0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        hold_cnt <= 4'd0;
        if (overflow || underflow) err <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              if (lo < hi) begin
                lo_q      <= lo;
                hi_q      <= hi;
                sweeps_q  <= sweeps;
                sweep_idx <= 4'd0;
                err       <= 1'b0;
                state     <= S_SEEK;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_SEEK: begin
            if (cnt == lo_q) state <= S_UP;
          end
          S_UP: begin
            if (cnt == hi_q) begin
              hold_cnt <= 4'd0;
              state    <= S_HOLD_TOP;
            end
          end
          S_HOLD_TOP: begin
            if (hold_done) begin
              hold_cnt <= 4'd0;
              state    <= S_DOWN;
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end
          S_DOWN: begin
            if (cnt == lo_q) begin
              sweep_idx <= sweep_idx + 4'd1;
              hold_cnt  <= 4'd0;
              state     <= S_HOLD_BOT;
            end
          end
          S_HOLD_BOT: begin
            if (hold_done) begin
              hold_cnt <= 4'd0;
              // sweeps_q == 0 is reached only when sweep_idx wraps after the 16th sweep.
              if (sweep_idx != sweeps_q) begin
                state <= S_UP;
              end else begin
                done  <= 1'b1;
                state <= S_IDLE;
              end
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter4_sweep_ctrl.sv
// Bench: controller closed around a plain 4-bit up/down counter; expected per-cycle outputs
// are generated per job from the sweep rules and compared every cycle.
module tb_counter4_sweep_ctrl;

  localparam int HOLD = 2;

  typedef struct packed {
    logic [3:0] cnt;
    logic       en;
    logic       up;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] idx;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       plant_rst_n;
  logic       start, stop, overflow, underflow;
  logic [3:0] lo, hi, sweeps, cnt;
  logic       en, up_down, busy, done, err;
  logic [3:0] sweep_idx;

  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  rec_t exp_q[$];
  rec_t job_q[$];
  logic m_err = 1'b0;
  logic [3:0] m_idx = 4'd0;
  rec_t cmp_r, cmp_a;

  counter4_sweep_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .lo(lo), .hi(hi), .sweeps(sweeps), .cnt(cnt),
    .overflow(overflow), .underflow(underflow),
    .en(en), .up_down(up_down), .busy(busy), .done(done),
    .err(err), .sweep_idx(sweep_idx)
  );

  always #5 clk = ~clk;

  // The controlled counter; wrap flags are driven by the bench only.
  always_ff @(posedge clk or negedge plant_rst_n) begin
    if (!plant_rst_n) cnt <= 4'd0;
    else if (en) cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_r = exp_q.pop_front();
      cmp_a = {cnt, en, up_down, busy, done, err, sweep_idx};
      total++;
      if (cmp_a !== cmp_r) begin
        bad++;
        $display("FAIL cycle_chk t=%0t got{cnt,en,ud,busy,done,err,idx}=%h want=%h", $time, cmp_a, cmp_r);
      end
    end
    if (done === 1'b1) done_seen++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int c, input bit e, input bit u, input bit b,
                              input bit dn, input bit er, input int ix);
    rec_t r;
    r.cnt = 4'(c); r.en = e; r.up = u; r.busy = b; r.done = dn; r.err = er; r.idx = 4'(ix);
    return r;
  endfunction

  // Expected cycle-by-cycle outputs of one complete job, starting with the start cycle.
  task automatic build_job(input logic [3:0] c0, input logic [3:0] lo_v,
                           input logic [3:0] hi_v, input logic [3:0] sw_v);
    int c, s_tot, d, l, h;
    l = int'(lo_v); h = int'(hi_v);
    job_q.delete();
    job_q.push_back(mk(int'(c0), 1'b0, 1'b1, 1'b0, 1'b0, m_err, int'(m_idx)));
    if (lo_v >= hi_v) begin
      job_q.push_back(mk(int'(c0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, int'(m_idx)));
      return;
    end
    c = int'(c0);
    for (int j = 0; j < 16; j++) begin
      job_q.push_back(mk(c, c != l, 1'b1, 1'b1, 1'b0, 1'b0, 0));
      if (c == l) break;
      c = (c + 1) % 16;
    end
    s_tot = (sw_v == 4'd0) ? 16 : int'(sw_v);
    d = (HOLD == 0) ? 1 : HOLD;
    for (int s = 1; s <= s_tot; s++) begin
      for (int v = l; v <= h; v++) job_q.push_back(mk(v, v != h, 1'b1, 1'b1, 1'b0, 1'b0, s - 1));
      for (int j = 0; j < d; j++) job_q.push_back(mk(h, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, s - 1));
      for (int v = h; v >= l; v--) job_q.push_back(mk(v, v != l, 1'b0, 1'b1, 1'b0, 1'b0, s - 1));
      for (int j = 0; j < d; j++) job_q.push_back(mk(l, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, s % 16));
    end
    job_q.push_back(mk(l, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, s_tot % 16));
  endtask

  // mode 1: stop at cycle k; mode 2: wrap flag at cycle k; mode 4: start and stop together.
  task automatic apply_abort(input int mode, input int k);
    rec_t r;
    if (mode == 4) begin
      r = job_q[0];
      job_q.delete();
      job_q.push_back(r);
      job_q.push_back(r);
    end else if (mode == 1 || mode == 2) begin
      while (job_q.size() > k + 1) void'(job_q.pop_back());
      r = job_q[k];
      r.en = 1'b0;
      job_q[k] = r;
      job_q.push_back(mk(int'(r.cnt), 1'b0, 1'b1, 1'b0, 1'b0, (mode == 2) ? 1'b1 : r.err, int'(r.idx)));
    end
  endtask

  task automatic drive_job(input logic [3:0] lo_v, input logic [3:0] hi_v,
                           input logic [3:0] sw_v, input int mode, input int k);
    int  n;
    bit  fl;
    n  = job_q.size();
    fl = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        foreach (job_q[j]) exp_q.push_back(job_q[j]);
        lo = lo_v; hi = hi_v; sweeps = sw_v;
        start = 1'b1; stop = (mode == 4); overflow = 1'b0; underflow = 1'b0;
      end else begin
        lo = 4'($urandom); hi = 4'($urandom); sweeps = 4'($urandom);
        if (job_q[i].busy) begin
          start     = 1'($urandom_range(0, 1));
          stop      = (mode == 1 && i == k);
          overflow  = (mode == 2 && i == k && fl);
          underflow = (mode == 2 && i == k && !fl);
        end else begin
          start     = 1'b0;
          stop      = 1'($urandom_range(0, 1));
          overflow  = 1'($urandom_range(0, 1));
          underflow = 1'($urandom_range(0, 1));
        end
      end
    end
    m_err = job_q[n-1].err;
    m_idx = job_q[n-1].idx;
  endtask

  initial begin
    int d0, k, mode;
    logic [3:0] lo_v, hi_v, sw_v, ck;
    rst_n = 1'b0; plant_rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; overflow = 1'b0; underflow = 1'b0;
    lo = 4'd0; hi = 4'd0; sweeps = 4'd0;
    #2;
    check("rst_init", int'({en, up_down, busy, done, err, sweep_idx}), int'(9'b010000000));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; plant_rst_n = 1'b1;

    // lo=2 hi=5 one sweep from cnt=0
    build_job(cnt, 4'd2, 4'd5, 4'd1);
    check("r033_len", job_q.size(), 17);
    d0 = done_seen;
    drive_job(4'd2, 4'd5, 4'd1, 0, -1);
    @(negedge clk); #1;
    check("r033_done", done_seen - d0, 1);
    check("r033_idx", int'(sweep_idx), 1);
    check("r033_cnt", int'(cnt), 2);

    // lo == hi rejected
    build_job(cnt, 4'd6, 4'd6, 4'd1);
    drive_job(4'd6, 4'd6, 4'd1, 0, -1);
    @(negedge clk); #1;
    check("r034_err", int'(err), 1);
    check("r034_busy", int'(busy), 0);

    // stop in UP at cnt=4
    build_job(cnt, 4'd2, 4'd5, 4'd1);
    k = -1;
    for (int i = 1; i < job_q.size(); i++)
      if (k < 0 && job_q[i].busy && job_q[i].up && job_q[i].en && job_q[i].cnt == 4'd4) k = i;
    check("r036_k", k, 4);
    apply_abort(1, k);
    d0 = done_seen;
    drive_job(4'd2, 4'd5, 4'd1, 1, k);
    @(negedge clk); #1;
    check("r036_busy", int'(busy), 0);
    check("r036_cnt", int'(cnt), 4);
    check("r036_done", done_seen - d0, 0);

    // park the counter at 9, then seek through the wrap
    build_job(cnt, 4'd9, 4'd12, 4'd1);
    drive_job(4'd9, 4'd12, 4'd1, 0, -1);
    @(negedge clk); #1;
    check("pre037_cnt", int'(cnt), 9);
    build_job(4'd9, 4'd3, 4'd7, 4'd1);
    check("r037_len", job_q.size(), 27);
    drive_job(4'd3, 4'd7, 4'd1, 0, -1);
    @(negedge clk); #1;
    check("r037_cnt", int'(cnt), 3);

    // full range, three sweeps
    build_job(cnt, 4'd0, 4'd15, 4'd3);
    d0 = done_seen;
    drive_job(4'd0, 4'd15, 4'd3, 0, -1);
    @(negedge clk); #1;
    check("r035_idx", int'(sweep_idx), 3);
    check("r035_done", done_seen - d0, 1);

    // reset mid DOWN, then wrap flags in IDLE
    build_job(cnt, 4'd1, 4'd8, 4'd2);
    k = -1;
    for (int i = 1; i < job_q.size(); i++)
      if (k < 0 && job_q[i].busy && !job_q[i].up && job_q[i].en) k = i;
    ck = job_q[k].cnt;
    while (job_q.size() > k) void'(job_q.pop_back());
    drive_job(4'd1, 4'd8, 4'd2, 0, -1);
    stop = 1'b0; overflow = 1'b0; underflow = 1'b0; start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("r038_async", int'({en, up_down, busy, done, err, sweep_idx}), int'(9'b010000000));
    m_err = 1'b0; m_idx = 4'd0;
    @(posedge clk); #1;
    rst_n = 1'b1; overflow = 1'b1;
    exp_q.push_back(mk(int'(ck), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    @(posedge clk); #1;
    overflow = 1'b0; underflow = 1'b1;
    exp_q.push_back(mk(int'(ck), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    @(posedge clk); #1;
    underflow = 1'b0;
    exp_q.push_back(mk(int'(ck), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    @(negedge clk); #1;
    check("r038_err", int'(err), 0);

    // randomized jobs with aborts, bad bounds and start/stop collisions
    for (int t = 0; t < 40; t++) begin
      lo_v = 4'($urandom_range(0, 14));
      hi_v = 4'($urandom_range(int'(lo_v) + 1, 15));
      if ($urandom_range(0, 5) == 0) hi_v = 4'($urandom_range(0, int'(lo_v)));
      sw_v = 4'($urandom_range(0, 3));
      if (lo_v >= hi_v) mode = 0;
      else begin
        case ($urandom_range(0, 5))
          3: mode = 1;
          4: mode = 2;
          5: mode = 4;
          default: mode = 0;
        endcase
      end
      build_job(cnt, lo_v, hi_v, sw_v);
      k = -1;
      if (mode == 1 || mode == 2) k = $urandom_range(1, job_q.size() - 2);
      apply_abort(mode, k);
      drive_job(lo_v, hi_v, sw_v, mode, k);
    end
    @(negedge clk); #1;
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
